// File: rtl/stack_sequencer.sv
// Stack traffic sequencer: splits PUSH/POP/CALL/RET/INT/RTI into 16-bit word transfers.
// Optional occupancy bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_sequencer #(
   parameter int STACK_TOP = 2047,
   parameter int DEPTH     = 2048,
   parameter int FLAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_data,
   input  logic [FLAG_W-1:0] req_flags,
   output logic              req_ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       rsp_data,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic              sp_en,
   output logic              sp_pop,
   input  logic [31:0]       sp,
   output logic              mem_we,
   output logic              mem_re,
   output logic [31:0]       mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_INT  = 3'd4;
   localparam logic [2:0] OP_RTI  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

   // The stack must fit entirely below its reset top.
   if (STACK_TOP + 1 < DEPTH) begin : g_bad_cfg
      $error("stack_sequencer: DEPTH exceeds STACK_TOP + 1");
   end

   function automatic logic [1:0] word_count(input logic [2:0] op);
      case (op)
         OP_PUSH, OP_POP: return 2'd1;
         OP_CALL, OP_RET: return 2'd2;
         OP_INT,  OP_RTI: return 2'd3;
         default:         return 2'd0;
      endcase
   endfunction

   function automatic logic is_pop(input logic [2:0] op);
      return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
   endfunction

   // High PC half goes out first so the pop side restores low half first.
   function automatic logic [15:0] push_word(input logic [2:0] op, input logic [1:0] k,
                                             input logic [31:0] pc, input logic [FLAG_W-1:0] fl);
      case (op)
         OP_PUSH: return pc[15:0];
         OP_CALL: return (k == 2'd0) ? pc[31:16] : pc[15:0];
         OP_INT:  return (k == 2'd0) ? pc[31:16] : (k == 2'd1) ? pc[15:0] : 16'(fl);
         default: return 16'h0000;
      endcase
   endfunction

   state_t            state;
   logic [2:0]        op_q;
   logic [31:0]       pc_q;
   logic [FLAG_W-1:0] fl_q;
   logic [1:0]        n_q;
   logic [1:0]        idx;
   logic [15:0]       rx_lo;
   logic [FLAG_W-1:0] rx_flags;
   logic [1:0]        req_n;
   logic              req_pop;
   logic              reject;

`ifdef STACK_BOUNDS_CHECK_EN
   logic [11:0] count;
`endif

   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      req_n   = word_count(req_op);
      req_pop = is_pop(req_op);
      reject  = (req_n == 2'd0);
`ifdef STACK_BOUNDS_CHECK_EN
      if (req_pop)
         reject = reject || (13'(count) < 13'(req_n));
      else
         reject = reject || (13'(count) + 13'(req_n) > 13'(DEPTH));
`endif
   end

   // Address tracks the live SP: writes land at sp, reads come from sp+1.
   assign mem_addr = mem_we ? sp : (mem_re ? sp + 32'd1 : 32'd0);

   // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= 3'd0;
         pc_q      <= 32'd0;
         fl_q      <= '0;
         n_q       <= 2'd0;
         idx       <= 2'd0;
         rx_lo     <= 16'd0;
         rx_flags  <= '0;
         req_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_flags <= '0;
         sp_en     <= 1'b0;
         sp_pop    <= 1'b0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_wdata <= 16'd0;
`ifdef STACK_BOUNDS_CHECK_EN
         count     <= 12'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  pc_q      <= req_data;
                  fl_q      <= req_flags;
                  n_q       <= req_n;
                  idx       <= 2'd0;
                  req_ready <= 1'b0;
                  if (reject) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state     <= S_XFER;
                     sp_en     <= 1'b1;
                     sp_pop    <= req_pop;
                     mem_we    <= !req_pop;
                     mem_re    <= req_pop;
                     mem_wdata <= req_pop ? 16'd0 : push_word(req_op, 2'd0, req_data, req_flags);
                  end
               end
            end

            S_XFER: begin
               if (sp_pop) begin
                  case (op_q)
                     OP_POP: rsp_data <= {16'h0000, mem_rdata};
                     OP_RET: begin
                        if (idx == 2'd0) rx_lo <= mem_rdata;
                        else             rsp_data <= {mem_rdata, rx_lo};
                     end
                     OP_RTI: begin
                        if (idx == 2'd0)      rx_flags <= mem_rdata[FLAG_W-1:0];
                        else if (idx == 2'd1) rx_lo    <= mem_rdata;
                        else begin
                           rsp_data  <= {mem_rdata, rx_lo};
                           rsp_flags <= rx_flags;
                        end
                     end
                     default: ;
                  endcase
               end
`ifdef STACK_BOUNDS_CHECK_EN
               count <= sp_pop ? count - 12'd1 : count + 12'd1;
`endif
               if (idx == n_q - 2'd1) begin
                  state     <= S_DONE;
                  sp_en     <= 1'b0;
                  sp_pop    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_re    <= 1'b0;
                  mem_wdata <= 16'd0;
                  done      <= 1'b1;
                  err       <= 1'b0;
               end else begin
                  idx       <= idx + 2'd1;
                  mem_wdata <= sp_pop ? 16'd0 : push_word(op_q, idx + 2'd1, pc_q, fl_q);
               end
            end

            S_DONE: begin
               state     <= S_IDLE;
               done      <= 1'b0;
               err       <= 1'b0;
               req_ready <= 1'b1;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a stack-pointer and data-memory model.
// Expectations adapt to STACK_BOUNDS_CHECK_EN when it is defined for the build.
module tb_stack_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_data;
   logic [3:0]  req_flags;
   logic        req_ready, done, err;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic        sp_en, sp_pop, mem_we, mem_re;
   logic [31:0] sp, mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] mem [0:4095];

   int n_cmp = 0;
   int n_bad = 0;

   stack_sequencer #(.STACK_TOP(2047), .DEPTH(2048), .FLAG_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_flags(req_flags), .req_ready(req_ready), .done(done), .err(err),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .sp_en(sp_en), .sp_pop(sp_pop), .sp(sp),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Stack pointer block: post-decrement on push, pre-increment on pop.
   always @(posedge clk) begin
      if (rst)        sp <= 32'd2047;
      else if (sp_en) sp <= sp_pop ? sp + 32'd1 : sp - 32'd1;
   end

   always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[11:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents one request for one cycle; returns at the negedge of cycle T+1.
   task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [3:0] flags);
      @(negedge clk);
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      req_flags = flags;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic word(input string tag, input logic pop, input logic [31:0] addr,
                       input logic [15:0] wdata);
      check({tag, "_strobes"}, 32'({sp_en, sp_pop, mem_we, mem_re}), 32'({1'b1, pop, !pop, pop}));
      check({tag, "_addr"}, mem_addr, addr);
      if (!pop) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
      @(negedge clk);
   endtask

   task automatic finish_op(input string tag, input logic exp_err);
      check({tag, "_done"}, 32'({done, err, req_ready}), 32'({1'b1, exp_err, 1'b0}));
      @(negedge clk);
      check({tag, "_idle"}, 32'({done, req_ready, sp_en}), 32'({1'b0, 1'b1, 1'b0}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_data = 32'd0; req_flags = 4'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_ctrl", 32'({req_ready, done, err, sp_en, sp_pop, mem_we, mem_re}), 32'h40);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rsp", rsp_data, 32'd0);
      check("rst_rflags", 32'(rsp_flags), 32'd0);
      check("rst_sp", sp, 32'd2047);

      // PUSH then POP of a single word
      issue(3'd0, 32'hFFFF_1234, 4'd0);
      word("push", 1'b0, 32'd2047, 16'h1234);
      finish_op("push", 1'b0);
      check("push_sp", sp, 32'd2046);
      issue(3'd1, 32'd0, 4'd0);
      word("pop", 1'b1, 32'd2047, 16'h0000);
      finish_op("pop", 1'b0);
      check("pop_rsp", rsp_data, 32'h0000_1234);
      check("pop_sp", sp, 32'd2047);

      // CALL / RET
      issue(3'd2, 32'hDEAD_BEEF, 4'd0);
      word("call0", 1'b0, 32'd2047, 16'hDEAD);
      word("call1", 1'b0, 32'd2046, 16'hBEEF);
      finish_op("call", 1'b0);
      check("call_mem_hi", 32'(mem[2047]), 32'h0000_DEAD);
      check("call_mem_lo", 32'(mem[2046]), 32'h0000_BEEF);
      issue(3'd3, 32'd0, 4'd0);
      word("ret0", 1'b1, 32'd2046, 16'h0000);
      word("ret1", 1'b1, 32'd2047, 16'h0000);
      finish_op("ret", 1'b0);
      check("ret_rsp", rsp_data, 32'hDEAD_BEEF);
      check("ret_sp", sp, 32'd2047);

      // INT / RTI, with a stray request during INT that must be ignored
      issue(3'd4, 32'h0040_0010, 4'b1010);
      req_valid = 1'b1; req_op = 3'd1;
      word("int0", 1'b0, 32'd2047, 16'h0040);
      word("int1", 1'b0, 32'd2046, 16'h0010);
      req_valid = 1'b0;
      word("int2", 1'b0, 32'd2045, 16'h000A);
      finish_op("int", 1'b0);
      check("int_sp", sp, 32'd2044);
      issue(3'd5, 32'd0, 4'd0);
      word("rti0", 1'b1, 32'd2045, 16'h0000);
      word("rti1", 1'b1, 32'd2046, 16'h0000);
      word("rti2", 1'b1, 32'd2047, 16'h0000);
      finish_op("rti", 1'b0);
      check("rti_rflags", 32'(rsp_flags), 32'hA);
      check("rti_rsp", rsp_data, 32'h0040_0010);
      check("rti_sp", sp, 32'd2047);

      // Illegal opcode: immediate error, no traffic, response held
      issue(3'd7, 32'h1111_2222, 4'd0);
      check("ill_strobes", 32'({sp_en, mem_we, mem_re}), 32'd0);
      finish_op("ill", 1'b1);
      check("ill_sp", sp, 32'd2047);
      check("ill_rsp_hold", rsp_data, 32'h0040_0010);

      // POP on an empty stack
      issue(3'd1, 32'd0, 4'd0);
`ifdef STACK_BOUNDS_CHECK_EN
      check("empty_strobes", 32'({sp_en, mem_we, mem_re}), 32'd0);
      finish_op("empty", 1'b1);
      check("empty_sp", sp, 32'd2047);
`else
      word("empty", 1'b1, 32'd2048, 16'h0000);
      finish_op("empty", 1'b0);
      check("empty_rsp", rsp_data, 32'd0);
      check("empty_sp", sp, 32'd2048);
`endif

      // Reset in the second word of INT aborts the operation
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(3'd4, 32'hCAFE_F00D, 4'b0110);
      word("abort0", 1'b0, 32'd2047, 16'hCAFE);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", 32'({done, req_ready, sp_en, mem_we}), 32'b0100);
      check("abort_sp", sp, 32'd2047);
      issue(3'd0, 32'h0000_5555, 4'd0);
      word("post_abort", 1'b0, 32'd2047, 16'h5555);
      finish_op("post_abort", 1'b0);
      check("post_abort_sp", sp, 32'd2046);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
